param_reservation_station: RTL and testbench

PARAM_RESERVATION_STATION -- requirements
Module: param_reservation_station

---
 rtl/param_reservation_station.sv | 156 +++++++++++++++
 tb/tb_param_reservation_station.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/param_reservation_station.sv
// param_reservation_station: age-ordered reservation station with wake-up bypass feeding one ALU port
module param_reservation_station #(
   parameter int DEPTH = 16,
   parameter int ROB_W = 5,
   parameter int NWAKE = 5,
   parameter int XLEN  = 32
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    _clear,
   input  logic                    _rs_ready,
   input  logic [6:0]              _rs_type,
   input  logic [3:0]              _rs_op,
   input  logic [ROB_W-1:0]        _rs_rob_id,
   input  logic [XLEN-1:0]         _rs_r1,
   input  logic [XLEN-1:0]         _rs_r2,
   input  logic [XLEN-1:0]         _rs_imm,
   input  logic                    _rs_has_dep1,
   input  logic                    _rs_has_dep2,
   input  logic [ROB_W-1:0]        _rs_dep1,
   input  logic [ROB_W-1:0]        _rs_dep2,
   output logic                    _rs_full,
   output logic [$clog2(DEPTH):0]  _rs_count,
   input  logic [NWAKE-1:0]        _wk_valid,
   input  logic [NWAKE*ROB_W-1:0]  _wk_rob_id,
   input  logic [NWAKE*XLEN-1:0]   _wk_value,
   input  logic                    _alu_full,
   output logic                    _alu_ready,
   output logic [ROB_W-1:0]        _alu_rob_id,
   output logic [6:0]              _alu_type,
   output logic [3:0]              _alu_op,
   output logic [XLEN-1:0]         _alu_v1,
   output logic [XLEN-1:0]         _alu_v2
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [DEPTH-1:0] busy, pend1, pend2, elig, hit1, hit2;
   logic [DEPTH-1:0] older [DEPTH];
   logic [ROB_W-1:0] rob [DEPTH];
   logic [ROB_W-1:0] dep1 [DEPTH];
   logic [ROB_W-1:0] dep2 [DEPTH];
   logic [6:0]       typ [DEPTH];
   logic [3:0]       op [DEPTH];
   logic [XLEN-1:0]  v1 [DEPTH];
   logic [XLEN-1:0]  v2 [DEPTH];
   logic [XLEN-1:0]  imm [DEPTH];
   logic [XLEN-1:0]  wv1 [DEPTH];
   logic [XLEN-1:0]  wv2 [DEPTH];
   logic             in_hit1, in_hit2;
   logic [XLEN-1:0]  in_v1, in_v2;
   logic [CW-1:0]    count;
   logic [IW-1:0]    sel, free_idx;
   logic             do_enq;

   // Wake-up match per source; channels scanned high to low so the lowest matching channel wins
   always_comb begin
      hit1 = '0;
      hit2 = '0;
      in_hit1 = 1'b0;
      in_hit2 = 1'b0;
      in_v1 = '0;
      in_v2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wv1[i] = v1[i];
         wv2[i] = v2[i];
      end
      for (int k = NWAKE-1; k >= 0; k--) begin
         if (_wk_valid[k]) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (_wk_rob_id[k*ROB_W +: ROB_W] == dep1[i]) begin
                  hit1[i] = 1'b1;
                  wv1[i] = _wk_value[k*XLEN +: XLEN];
               end
               if (_wk_rob_id[k*ROB_W +: ROB_W] == dep2[i]) begin
                  hit2[i] = 1'b1;
                  wv2[i] = _wk_value[k*XLEN +: XLEN];
               end
            end
            if (_wk_rob_id[k*ROB_W +: ROB_W] == _rs_dep1) begin
               in_hit1 = 1'b1;
               in_v1 = _wk_value[k*XLEN +: XLEN];
            end
            if (_wk_rob_id[k*ROB_W +: ROB_W] == _rs_dep2) begin
               in_hit2 = 1'b1;
               in_v2 = _wk_value[k*XLEN +: XLEN];
            end
         end
      end
   end

   // Oldest eligible entry (none of its recorded elders is eligible) and lowest free slot
   always_comb begin
      elig = busy & ~pend1 & ~pend2;
      sel = '0;
      free_idx = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (elig[i] && !(|(older[i] & elig))) sel = IW'(i);
         if (!busy[i]) free_idx = IW'(i);
      end
   end

   assign _rs_full    = count == CW'(DEPTH);
   assign _rs_count   = count;
   assign do_enq      = _rs_ready && rdy_in && !_rs_full;
   assign _alu_ready  = |elig && !_alu_full && rdy_in;
   assign _alu_rob_id = rob[sel];
   assign _alu_type   = typ[sel];
   assign _alu_op     = op[sel];
   assign _alu_v1     = v1[sel];
   assign _alu_v2     = (typ[sel] == 7'b0110011 || typ[sel] == 7'b1100011) ? v2[sel] : imm[sel];

   // Occupancy, pending flags and age matrix; older[i][j] means entry j arrived before entry i
   always_ff @(posedge clk_in) begin
      if (rst_in || _clear) begin
         busy <= '0;
         pend1 <= '0;
         pend2 <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      end else if (rdy_in) begin
         pend1 <= pend1 & ~hit1;
         pend2 <= pend2 & ~hit2;
         if (_alu_ready) busy[sel] <= 1'b0;
         if (do_enq) begin
            for (int i = 0; i < DEPTH; i++) older[i][free_idx] <= 1'b0;
            older[free_idx] <= busy;
            busy[free_idx] <= 1'b1;
            pend1[free_idx] <= _rs_has_dep1 && !in_hit1;
            pend2[free_idx] <= _rs_has_dep2 && !in_hit2;
         end
         count <= count + CW'(do_enq) - CW'(_alu_ready);
      end
   end

   // Entry payload: operand capture on wake-up and field load on enqueue with bypass
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (busy[i] && pend1[i] && hit1[i]) v1[i] <= wv1[i];
            if (busy[i] && pend2[i] && hit2[i]) v2[i] <= wv2[i];
         end
         if (do_enq) begin
            rob[free_idx] <= _rs_rob_id;
            typ[free_idx] <= _rs_type;
            op[free_idx] <= _rs_op;
            imm[free_idx] <= _rs_imm;
            dep1[free_idx] <= _rs_dep1;
            dep2[free_idx] <= _rs_dep2;
            v1[free_idx] <= (_rs_has_dep1 && in_hit1) ? in_v1 : _rs_r1;
            v2[free_idx] <= (_rs_has_dep2 && in_hit2) ? in_v2 : _rs_r2;
         end
      end
   end
endmodule

// File: tb/tb_param_reservation_station.sv
// tb_param_reservation_station: directed and random checks against a sequence-numbered entry model
module tb_param_reservation_station;
   localparam int DEPTH = 16, ROB_W = 5, NWAKE = 5, XLEN = 32, CW = $clog2(DEPTH) + 1;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic rst_in, rdy_in, clear, rs_ready, hd1, hd2, alu_full;
   logic [6:0] rs_type;
   logic [3:0] rs_op;
   logic [ROB_W-1:0] rs_rob, d1, d2;
   logic [XLEN-1:0] r1, r2, imm;
   logic [NWAKE-1:0] wk_valid;
   logic [NWAKE*ROB_W-1:0] wk_rob;
   logic [NWAKE*XLEN-1:0] wk_val;
   logic rs_full, alu_ready;
   logic [CW-1:0] rs_count;
   logic [ROB_W-1:0] alu_rob;
   logic [6:0] alu_type;
   logic [3:0] alu_op;
   logic [XLEN-1:0] alu_v1, alu_v2;

   param_reservation_station #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NWAKE(NWAKE), .XLEN(XLEN)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(clear),
      ._rs_ready(rs_ready), ._rs_type(rs_type), ._rs_op(rs_op), ._rs_rob_id(rs_rob),
      ._rs_r1(r1), ._rs_r2(r2), ._rs_imm(imm), ._rs_has_dep1(hd1), ._rs_has_dep2(hd2),
      ._rs_dep1(d1), ._rs_dep2(d2), ._rs_full(rs_full), ._rs_count(rs_count),
      ._wk_valid(wk_valid), ._wk_rob_id(wk_rob), ._wk_value(wk_val), ._alu_full(alu_full),
      ._alu_ready(alu_ready), ._alu_rob_id(alu_rob), ._alu_type(alu_type), ._alu_op(alu_op),
      ._alu_v1(alu_v1), ._alu_v2(alu_v2)
   );

   int tests = 0, fails = 0;

   bit m_busy [DEPTH];
   bit m_p1 [DEPTH];
   bit m_p2 [DEPTH];
   int m_seq [DEPTH];
   int seq_ctr = 0;
   logic [ROB_W-1:0] m_rob [DEPTH];
   logic [ROB_W-1:0] m_d1 [DEPTH];
   logic [ROB_W-1:0] m_d2 [DEPTH];
   logic [6:0] m_type [DEPTH];
   logic [3:0] m_op [DEPTH];
   logic [XLEN-1:0] m_v1 [DEPTH];
   logic [XLEN-1:0] m_v2 [DEPTH];
   logic [XLEN-1:0] m_imm [DEPTH];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void m_wake(input logic [ROB_W-1:0] t, output bit hit, output logic [XLEN-1:0] v);
      hit = 0;
      v = '0;
      for (int k = 0; k < NWAKE; k++)
         if (wk_valid[k] && wk_rob[k*ROB_W +: ROB_W] == t) begin
            hit = 1;
            v = wk_val[k*XLEN +: XLEN];
            break;
         end
   endfunction

   function automatic int m_pick();
      int s = -1;
      for (int i = 0; i < DEPTH; i++)
         if (m_busy[i] && !m_p1[i] && !m_p2[i] && (s < 0 || m_seq[i] < m_seq[s])) s = i;
      return s;
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   task automatic m_update(input int s, input bit issue);
      int e = -1;
      bit h;
      logic [XLEN-1:0] v;
      if (rst_in || clear) begin
         for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
      end else if (rdy_in) begin
         if (rs_ready && m_count() < DEPTH)
            for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) begin e = i; break; end
         for (int i = 0; i < DEPTH; i++) if (m_busy[i]) begin
            if (m_p1[i]) begin m_wake(m_d1[i], h, v); if (h) begin m_p1[i] = 0; m_v1[i] = v; end end
            if (m_p2[i]) begin m_wake(m_d2[i], h, v); if (h) begin m_p2[i] = 0; m_v2[i] = v; end end
         end
         if (issue) m_busy[s] = 0;
         if (e >= 0) begin
            m_busy[e] = 1;
            m_rob[e] = rs_rob; m_type[e] = rs_type; m_op[e] = rs_op; m_imm[e] = imm;
            m_d1[e] = d1; m_d2[e] = d2;
            m_wake(d1, h, v); m_p1[e] = hd1 && !h; m_v1[e] = (hd1 && h) ? v : r1;
            m_wake(d2, h, v); m_p2[e] = hd2 && !h; m_v2[e] = (hd2 && h) ? v : r2;
            m_seq[e] = seq_ctr++;
         end
      end
   endtask

   task automatic cyc();
      int s;
      bit er;
      logic [XLEN-1:0] ev2;
      #1;
      s = m_pick();
      er = s >= 0 && !alu_full && rdy_in;
      check("ready", alu_ready, er);
      check("count", rs_count, m_count());
      check("full", rs_full, m_count() == DEPTH);
      if (er) begin
         ev2 = (m_type[s] == 7'b0110011 || m_type[s] == 7'b1100011) ? m_v2[s] : m_imm[s];
         check("rob", alu_rob, m_rob[s]);
         check("type", alu_type, m_type[s]);
         check("op", alu_op, m_op[s]);
         check("v1", alu_v1, m_v1[s]);
         check("v2", alu_v2, ev2);
      end
      m_update(s, er);
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      rst_in = 0; rdy_in = 1; clear = 0; rs_ready = 0; hd1 = 0; hd2 = 0; alu_full = 0;
      rs_type = 7'b0010011; rs_op = 0; rs_rob = 0; d1 = 0; d2 = 0; r1 = 0; r2 = 0; imm = 0;
      wk_valid = 0; wk_rob = '1; wk_val = 0;
   endtask

   task automatic enq(input logic [ROB_W-1:0] rb, input logic [6:0] t, input logic [XLEN-1:0] a, b, i,
                      input bit h1, input logic [ROB_W-1:0] e1, input bit h2, input logic [ROB_W-1:0] e2);
      rs_ready = 1; rs_rob = rb; rs_type = t; rs_op = rb[3:0]; r1 = a; r2 = b; imm = i;
      hd1 = h1; d1 = e1; hd2 = h2; d2 = e2;
   endtask

   initial begin
      idle();
      rst_in = 1;
      @(posedge clk_in);
      #1;
      rst_in = 0;
      check("rst_count", rs_count, 0);
      check("rst_ready", alu_ready, 0);
      check("rst_full", rs_full, 0);

      idle(); enq(3, 7'b0010011, 5, 0, 7, 0, 0, 0, 0); cyc();
      idle(); enq(4, 7'b0010011, 1, 0, 2, 0, 0, 0, 0); #1;
      check("A_rob", alu_rob, 3); check("A_v1", alu_v1, 5); check("A_v2", alu_v2, 7); cyc();
      idle(); #1; check("B_ready", alu_ready, 1); check("B_rob", alu_rob, 4); cyc();

      idle(); enq(6, 7'b0110011, 0, 2, 0, 1, 0, 0, 0); cyc();
      idle(); wk_valid = 5'b00100; wk_rob[2*ROB_W +: ROB_W] = 0; wk_val[2*XLEN +: XLEN] = 32'h11;
      #1; check("C_wait", alu_ready, 0); cyc();
      idle(); #1; check("C_ready", alu_ready, 1); check("C_rob", alu_rob, 6); check("C_v1", alu_v1, 32'h11); cyc();

      idle(); enq(7, 7'b0110011, 3, 0, 0, 0, 0, 1, 9);
      wk_valid = 5'b00001; wk_rob[ROB_W-1:0] = 9; wk_val[XLEN-1:0] = 32'hAB; cyc();
      idle(); #1; check("D_ready", alu_ready, 1); check("D_v2", alu_v2, 32'hAB); cyc();

      for (int i = 0; i < DEPTH; i++) begin
         idle(); alu_full = 1; enq(ROB_W'(i), 7'b0010011, i, 0, i + 100, 0, 0, 0, 0); cyc();
      end
      idle(); alu_full = 1; enq(20, 7'b0010011, 1, 1, 1, 0, 0, 0, 0); #1;
      check("full_set", rs_full, 1); check("full_hold", alu_ready, 0); cyc();
      idle(); alu_full = 1; #1; check("full_drop", rs_count, DEPTH); cyc();
      for (int i = 0; i < DEPTH; i++) begin
         idle(); #1; check("drain_rob", alu_rob, i); cyc();
      end

      for (int i = 0; i < 5; i++) begin
         idle(); alu_full = 1; enq(ROB_W'(i + 10), 7'b0010011, i, 0, i, 0, 0, 0, 0); cyc();
      end
      idle(); enq(30, 7'b0010011, 0, 0, 0, 0, 0, 0, 0); clear = 1; cyc();
      idle(); #1; check("clr_count", rs_count, 0); check("clr_ready", alu_ready, 0); cyc();
      repeat (3) begin idle(); cyc(); end

      idle(); alu_full = 1; enq(1, 7'b0110011, 0, 0, 0, 1, 12, 0, 0); cyc();
      idle(); alu_full = 1; enq(2, 7'b0110011, 0, 0, 0, 0, 0, 1, 13); cyc();
      idle(); alu_full = 1; enq(5, 7'b0010011, 9, 0, 4, 0, 0, 0, 0); cyc();
      repeat (3) begin
         idle(); rdy_in = 0; enq(8, 7'b0010011, 0, 0, 0, 0, 0, 0, 0);
         wk_valid = 5'b00011; wk_rob[ROB_W-1:0] = 12; wk_rob[2*ROB_W-1:ROB_W] = 13;
         #1; check("frz_ready", alu_ready, 0); check("frz_count", rs_count, 3); cyc();
      end
      repeat (4) begin idle(); cyc(); end

      for (int n = 0; n < 3000; n++) begin
         idle();
         rst_in = $urandom_range(0, 199) == 0;
         clear = $urandom_range(0, 99) == 0;
         rdy_in = $urandom_range(0, 9) != 0;
         alu_full = $urandom_range(0, 9) < 4;
         if ($urandom_range(0, 9) < 7) begin
            case ($urandom_range(0, 3))
               0: rs_type = 7'b0110011;
               1: rs_type = 7'b1100011;
               2: rs_type = 7'b0010011;
               default: rs_type = 7'($urandom);
            endcase
            enq(ROB_W'($urandom), rs_type, $urandom, $urandom, $urandom,
                1'($urandom), ROB_W'($urandom_range(0, 7)), 1'($urandom), ROB_W'($urandom_range(0, 7)));
         end
         wk_valid = NWAKE'($urandom);
         for (int k = 0; k < NWAKE; k++) begin
            wk_rob[k*ROB_W +: ROB_W] = ROB_W'($urandom_range(0, 7));
            wk_val[k*XLEN +: XLEN] = $urandom;
         end
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
